// File: rtl/fir_sm_buffer.sv
// fir_sm_buffer: output-side AXI-Stream buffer behind the fir sm_* master port.
// Samples are queued as {tlast, tdata} so consumer stalls never reach the FIR
// pipeline. The head word is presented through a registered fall-through stage.
// A frame FSM (IDLE/STREAM/FLUSH) tracks tlast, and frame_done pulses on the pop
// of each frame's last sample.
// level counts every accepted, not-yet-popped sample, including the presented head.
// Optional feature: define FIR_SM_BUFFER_HIGH_WATER_EN to track peak level.
module fir_sm_buffer #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 16,
    parameter int pCNT_WIDTH  = 16
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    output logic [pCNT_WIDTH-1:0]  level,
    output logic [pCNT_WIDTH-1:0]  sample_cnt,
    output logic                   frame_done,
    output logic                   busy,
    output logic [pCNT_WIDTH-1:0]  high_water
);

    localparam int AW = $clog2(pDEPTH);
    localparam logic [pCNT_WIDTH-1:0] FULL_LVL = pCNT_WIDTH'(pDEPTH);
    localparam logic [pCNT_WIDTH-1:0] TWO_LVL  = pCNT_WIDTH'(2);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t                state_q, state_nxt;
    logic [pDATA_WIDTH:0]  mem [pDEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr, rd_ptr_inc;
    logic [pCNT_WIDTH-1:0] level_nxt;
    logic [AW:0]           last_cnt;     // tlast words currently held
    logic                  push, pop, last_pop;

    assign s_tready   = (level != FULL_LVL);
    assign push       = s_tvalid & s_tready;
    assign pop        = m_tvalid & m_tready;
    assign last_pop   = pop & m_tlast;
    assign frame_done = last_pop;
    assign busy       = (state_q != IDLE);
    assign rd_ptr_inc = rd_ptr + 1'b1;

    // Occupancy after this edge.
    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    // Sample storage write port.
    // NOTE: storage is deliberately not reset; words are only read once written,
    // and m_tvalid gates everything that leaves the buffer.
    always_ff @(posedge axis_clk) begin
        if (push) mem[wr_ptr] <= {s_tlast, s_tdata};
    end

    // Pointers, level and the registered fall-through head stage.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
        end else begin
            level <= level_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                // Next head is presentable only if it was written on an earlier edge.
                rd_ptr   <= rd_ptr_inc;
                m_tvalid <= (level >= TWO_LVL);
                if (level >= TWO_LVL) {m_tlast, m_tdata} <= mem[rd_ptr_inc];
            end else if (!m_tvalid && level != '0) begin
                m_tvalid           <= 1'b1;
                {m_tlast, m_tdata} <= mem[rd_ptr];
            end
        end
    end

    // Count of frame ends still inside the buffer.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            last_cnt <= '0;
        end else begin
            case ({push & s_tlast, last_pop})
                2'b10:   last_cnt <= last_cnt + 1'b1;
                2'b01:   last_cnt <= last_cnt - 1'b1;
                default: last_cnt <= last_cnt;
            endcase
        end
    end

    // Per-frame output sample counter, saturating, cleared at frame end.
    always_ff @(posedge axis_clk) begin
        if (axis_rst)                         sample_cnt <= '0;
        else if (last_pop)                    sample_cnt <= '0;
        else if (pop && sample_cnt != '1)     sample_cnt <= sample_cnt + 1'b1;
    end

    // Frame FSM state register.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) state_q <= IDLE;
        else          state_q <= state_nxt;
    end

    // Frame FSM next state; a frame still queued behind a finished one resumes STREAM.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (push) state_nxt = s_tlast ? FLUSH : STREAM;
            STREAM:  if ((push && s_tlast) || last_cnt != '0) state_nxt = FLUSH;
            FLUSH:   if (last_pop) state_nxt = (level_nxt != '0) ? STREAM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef FIR_SM_BUFFER_HIGH_WATER_EN
    // Peak occupancy since reset.
    always_ff @(posedge axis_clk) begin
        if (axis_rst)                    high_water <= '0;
        else if (level_nxt > high_water) high_water <= level_nxt;
    end
`else
    assign high_water = '0;
`endif

endmodule

// File: tb/tb_fir_sm_buffer.sv
// Directed bench for fir_sm_buffer: pass-through, fill/drain, hold stability,
// back-to-back frames, mid-frame reset and the high-water field.
module tb_fir_sm_buffer;

    localparam int DW = 32;
    localparam int CW = 16;
`ifdef FIR_SM_BUFFER_HIGH_WATER_EN
    localparam int HW_EXP = 9;
`else
    localparam int HW_EXP = 0;
`endif

    logic          axis_clk = 1'b0;
    logic          axis_rst = 1'b1;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] s_tdata  = '0;
    logic          s_tlast  = 1'b0;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic [CW-1:0] level;
    logic [CW-1:0] sample_cnt;
    logic          frame_done;
    logic          busy;
    logic [CW-1:0] high_water;

    fir_sm_buffer #(.pDATA_WIDTH(DW), .pDEPTH(16), .pCNT_WIDTH(CW)) dut (
        .axis_clk  (axis_clk),
        .axis_rst  (axis_rst),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tdata   (s_tdata),
        .s_tlast   (s_tlast),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tlast   (m_tlast),
        .level     (level),
        .sample_cnt(sample_cnt),
        .frame_done(frame_done),
        .busy      (busy),
        .high_water(high_water)
    );

    always #5 axis_clk = ~axis_clk;

    int             checks = 0;
    int             errors = 0;
    logic [DW:0]    exp_q[$];
    int             fd_log[$];
    int             pop_idx = 0;
    logic           hold_pend = 1'b0;
    logic [DW:0]    hold_word = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: settle inputs, score handshakes, advance to just after the edge.
    task automatic cycle();
        logic [DW:0] w;
        #1;
        if (hold_pend) begin
            check("hold_valid", m_tvalid, 1);
            check("hold_data", {m_tlast, m_tdata}, hold_word);
        end
        if (s_tvalid && s_tready && !axis_rst) exp_q.push_back({s_tlast, s_tdata});
        if (m_tvalid && m_tready && !axis_rst) begin
            pop_idx++;
            if (frame_done) fd_log.push_back(pop_idx);
            check("pop_has_exp", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("pop_data", {m_tlast, m_tdata}, w);
            end
        end
        hold_pend = m_tvalid && !m_tready && !axis_rst;
        hold_word = {m_tlast, m_tdata};
        @(posedge axis_clk);
        #1;
    endtask

    task automatic drain(input int budget);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int c = 0; c < budget && (level != 0 || m_tvalid); c++) cycle();
        check("drain_empty", level, 0);
        check("drain_sb_empty", exp_q.size(), 0);
    endtask

    int acc;
    logic pre;

    initial begin
        // Reset state
        @(posedge axis_clk); #1;
        cycle();
        check("rst_tready", s_tready, 1);
        axis_rst = 1'b0;
        check("rst_tvalid", m_tvalid, 0);
        check("rst_level", level, 0);
        check("rst_cnt", sample_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_fd", frame_done, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_hw", high_water, 0);

        // Pass-through, 600 samples, consumer always ready
        pop_idx = 0; fd_log.delete();
        m_tready = 1'b1;
        for (int i = 0; i < 600; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'(i * 7 + 3);
            s_tlast  = (i == 599);
            cycle();
            check("pt_lat0", m_tvalid, 0);
            check("pt_level0", level, 1);
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            cycle();
            check("pt_lat1", m_tvalid, 1);
            check("pt_data", m_tdata, 32'(i * 7 + 3));
            check("pt_level1", level <= 1, 1);
            check("pt_cnt", sample_cnt, i);
            check("pt_busy", busy, 1);
        end
        cycle();
        check("pt_pops", pop_idx, 600);
        check("pt_fd_n", fd_log.size(), 1);
        if (fd_log.size() == 1) check("pt_fd_at", fd_log[0], 600);
        check("pt_cnt_end", sample_cnt, 0);
        check("pt_busy_end", busy, 0);
        check("pt_hw", high_water, (HW_EXP == 0) ? 0 : 1);

        // Fill to full with consumer stalled, then drain
        pop_idx = 0; fd_log.delete();
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        acc = 0;
        for (int c = 0; c < 25; c++) begin
            s_tdata = 32'hA000 + 32'(acc);
            s_tlast = (acc == 19);
            pre = s_tready;
            cycle();
            if (pre) acc++;
        end
        check("fill_accepts", acc, 16);
        check("fill_level", level, 16);
        check("fill_tready", s_tready, 0);
        m_tready = 1'b1;
        s_tdata  = 32'hA000 + 32'(acc);
        s_tlast  = (acc == 19);
        check("fill_nosame", s_tready, 0);
        cycle();
        check("fill_reassert", s_tready, 1);
        for (int c = 0; c < 40 && acc < 20; c++) begin
            s_tdata = 32'hA000 + 32'(acc);
            s_tlast = (acc == 19);
            pre = s_tready;
            cycle();
            if (pre) acc++;
        end
        check("fill_all_in", acc, 20);
        drain(60);
        check("fill_pops", pop_idx, 20);
        check("fill_fd_n", fd_log.size(), 1);
        check("fill_busy", busy, 0);

        // Hold stability under random stalls (checked inside cycle())
        for (int c = 0; c < 300; c++) begin
            s_tvalid = 1'($urandom_range(0, 1));
            s_tdata  = $urandom;
            s_tlast  = ($urandom_range(0, 15) == 0);
            m_tready = 1'($urandom_range(0, 1));
            cycle();
        end
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        s_tdata  = 32'h5A5A_0001;
        m_tready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            pre = s_tready;
            cycle();
            if (pre) break;
        end
        drain(60);
        check("hold_busy_end", busy, 0);

        // Back-to-back frames: 3 samples then 2 samples, no gap
        pop_idx = 0; fd_log.delete();
        m_tready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'h100 + 32'(k);
            s_tlast  = (k == 2 || k == 4);
            cycle();
            check("b2b_busy", busy, 1);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        for (int c = 0; c < 10 && pop_idx < 5; c++) begin
            cycle();
            if (pop_idx < 5) check("b2b_busy", busy, 1);
        end
        check("b2b_pops", pop_idx, 5);
        check("b2b_fd_n", fd_log.size(), 2);
        if (fd_log.size() == 2) begin
            check("b2b_fd0", fd_log[0], 3);
            check("b2b_fd1", fd_log[1], 5);
        end
        check("b2b_idle", busy, 0);
        check("b2b_cnt", sample_cnt, 0);

        // Reset mid-frame after 5 pushes and 2 pops
        pop_idx = 0;
        m_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'h200 + 32'(k);
            s_tlast  = 1'b0;
            cycle();
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int c = 0; c < 10 && pop_idx < 2; c++) cycle();
        m_tready = 1'b0;
        check("mr_pops", pop_idx, 2);
        check("mr_cnt_pre", sample_cnt, 2);
        check("mr_level_pre", level, 3);
        axis_rst = 1'b1;
        cycle();
        axis_rst = 1'b0;
        exp_q.delete();
        check("mr_tvalid", m_tvalid, 0);
        check("mr_level", level, 0);
        check("mr_cnt", sample_cnt, 0);
        check("mr_busy", busy, 0);
        check("mr_tready", s_tready, 1);
        check("mr_hw", high_water, 0);
        s_tvalid = 1'b1;
        s_tdata  = -32'sd10;
        s_tlast  = 1'b1;
        cycle();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check("mr_one_busy", busy, 1);
        check("mr_one_lat0", m_tvalid, 0);
        cycle();
        check("mr_one_valid", m_tvalid, 1);
        check("mr_one_data", m_tdata, 32'hFFFF_FFF6);
        check("mr_one_last", m_tlast, 1);
        m_tready = 1'b1;
        #1;
        check("mr_one_fd", frame_done, 1);
        cycle();
        check("mr_one_level", level, 0);
        check("mr_one_idle", busy, 0);
        check("mr_one_cnt", sample_cnt, 0);

        // High-water: stall until level reaches 9, then drain
        m_tready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'h300 + 32'(k);
            s_tlast  = (k == 8);
            cycle();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check("hw_level", level, 9);
        drain(40);
        check("hw_peak", high_water, HW_EXP);
        check("hw_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
